// File: rtl/strobe_decoder_if.sv
// Bus bundle for strobe_decoder: enables, request/address in, strobes and status out.
// With STROBE_DECODER_ERR_EN defined the bundle also carries the sticky err flag.
interface strobe_decoder_if #(
    parameter int WIDTH_OUT = 8,
    parameter int WIDTH_IN  = $clog2(WIDTH_OUT)
);
    logic                 Enable1_bar;
    logic                 Enable2_bar;
    logic                 Enable3;
    logic                 req;
    logic [WIDTH_IN-1:0]  A;
    logic [WIDTH_OUT-1:0] Y;
    logic                 busy;
    logic                 done;
`ifdef STROBE_DECODER_ERR_EN
    logic                 err;
`endif

    modport master (
        output Enable1_bar, Enable2_bar, Enable3, req, A,
        input  Y, busy, done
`ifdef STROBE_DECODER_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  Enable1_bar, Enable2_bar, Enable3, req, A,
        output Y, busy, done
`ifdef STROBE_DECODER_ERR_EN
        , output err
`endif
    );
endinterface

// File: rtl/strobe_decoder.sv
// Sequenced active-low strobe decoder: latches an address on request and drives
// a glitch-free low pulse on Y[addr] framed by setup and hold phases.
// Every output comes straight from a flop; A never reaches Y combinationally.
// Optional macro STROBE_DECODER_ERR_EN adds a sticky err flag and rejects
// out-of-range or unknown addresses instead of running a silent sequence.
module strobe_decoder #(
    parameter int WIDTH_OUT    = 8,
    parameter int WIDTH_IN     = $clog2(WIDTH_OUT),
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input logic clk,
    input logic _MR,
    strobe_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, HOLD} state_t;

    localparam logic [WIDTH_OUT-1:0] ONE      = {{(WIDTH_OUT-1){1'b0}}, 1'b1};
    localparam logic [3:0]           SETUP_LD = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0]           PULSE_LD = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0]           HOLD_LD  = 4'(HOLD_CYCLES - 1);
`ifdef STROBE_DECODER_ERR_EN
    localparam logic [WIDTH_IN:0]    A_LIM    = (WIDTH_IN + 1)'(WIDTH_OUT);
`endif

    // One-hot low decode; shifting past the top leaves all ones (out-of-range
    // addresses stay silent) and an unknown address yields all X.
    function automatic logic [WIDTH_OUT-1:0] decode(input logic [WIDTH_IN-1:0] a);
        return ~(ONE << a);
    endfunction

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [WIDTH_IN-1:0]  addr_q, addr_d;
    logic [WIDTH_OUT-1:0] y_q, y_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 en;
`ifdef STROBE_DECODER_ERR_EN
    logic                 err_q, err_d;
`endif

    assign en = !bus.Enable1_bar && !bus.Enable2_bar && bus.Enable3;

    // Next-state and next-output logic; outputs default to idle (all high, no done).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        y_d     = '1;
        busy_d  = busy_q;
        done_d  = 1'b0;
        accept  = 1'b0;
`ifdef STROBE_DECODER_ERR_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.req && en) begin
`ifdef STROBE_DECODER_ERR_EN
                    // An unknown address fails the compare and lands in the error arm.
                    if ({1'b0, bus.A} < A_LIM) accept = 1'b1;
                    else                       err_d  = 1'b1;
`else
                    accept = 1'b1;
`endif
                end else if (!bus.req || !en) begin
                    y_d = '1;
                end else begin
                    // Request with an unknown enable: refuse to pretend the outputs are clean.
                    y_d = 'x;
                end
                if (accept) begin
                    addr_d = bus.A;
                    busy_d = 1'b1;
                    if (SETUP_CYCLES == 0) begin
                        state_d = ACTIVE;
                        cnt_d   = PULSE_LD;
                        y_d     = decode(bus.A);
                    end else begin
                        state_d = SETUP;
                        cnt_d   = SETUP_LD;
                    end
                end
            end
            SETUP: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ACTIVE;
                    cnt_d   = PULSE_LD;
                    y_d     = decode(addr_q);
                end
            end
            ACTIVE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                    y_d   = decode(addr_q);
                end else if (HOLD_CYCLES == 0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end
            end
            HOLD: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // Losing enable mid-sequence abandons it outright; no partial pulse survives.
        if (state_q != IDLE && !en) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            y_d     = '1;
`ifdef STROBE_DECODER_ERR_EN
            err_d   = 1'b1;
`endif
        end
    end

    // State and output registers; async reset forces the strobes high immediately.
    always_ff @(posedge clk or negedge _MR) begin
        if (!_MR) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            y_q     <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef STROBE_DECODER_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef STROBE_DECODER_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.Y    = y_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef STROBE_DECODER_ERR_EN
    assign bus.err  = err_q;
`endif
endmodule

// File: tb/tb_strobe_decoder.sv
// Scoreboard bench for strobe_decoder: a default 8-output instance and a
// 6-output zero-setup/zero-hold instance. Each stimulus step queues the
// outputs expected after the next rising edge; a monitor pops and compares.
module tb_strobe_decoder;
`ifdef STROBE_DECODER_ERR_EN
    localparam bit ERR_BUILD = 1'b1;
`else
    localparam bit ERR_BUILD = 1'b0;
`endif

    typedef struct {
        logic [7:0] y;
        logic       busy;
        logic       done;
        logic       err;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic mr_n;
    int   errors = 0;
    int   checks = 0;
    exp_t q8[$];
    exp_t q6[$];
    logic err8;
    logic [2:0] xa;
    logic [7:0] yx;
    logic       xunk;

    always #5 clk = ~clk;

    strobe_decoder_if #(.WIDTH_OUT(8)) b8();
    strobe_decoder_if #(.WIDTH_OUT(6)) b6();

    strobe_decoder u8 (.clk(clk), ._MR(mr_n), .bus(b8));
    strobe_decoder #(.WIDTH_OUT(6), .SETUP_CYCLES(0), .PULSE_CYCLES(1), .HOLD_CYCLES(0))
        u6 (.clk(clk), ._MR(mr_n), .bus(b6));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cmp(input exp_t e, input logic [7:0] y, input logic b, input logic d);
        chk({e.tag, " Y"}, y, e.y);
        chk({e.tag, " busy"}, {7'b0, b}, {7'b0, e.busy});
        chk({e.tag, " done"}, {7'b0, d}, {7'b0, e.done});
    endtask

    // Drive one cycle of inputs on the 8-output instance and queue its expected outputs.
    task automatic s8(input logic r, input logic e3, input logic [2:0] a,
                      input logic [7:0] y, input logic bz, input logic dn,
                      input logic er, input string t);
        exp_t e;
        @(negedge clk);
        b8.req = r; b8.Enable3 = e3; b8.A = a;
        e.y = y; e.busy = bz; e.done = dn; e.err = er; e.tag = t;
        q8.push_back(e);
    endtask

    task automatic s6(input logic r, input logic [2:0] a, input logic [5:0] y,
                      input logic bz, input logic dn, input logic er, input string t);
        exp_t e;
        @(negedge clk);
        b6.req = r; b6.A = a;
        e.y = {2'b00, y}; e.busy = bz; e.done = dn; e.err = er; e.tag = t;
        q6.push_back(e);
    endtask

    task automatic rst_chk(input string t);
        chk({t, " Y"}, b8.Y, 8'hFF);
        chk({t, " busy"}, {7'b0, b8.busy}, 8'h00);
        chk({t, " done"}, {7'b0, b8.done}, 8'h00);
`ifdef STROBE_DECODER_ERR_EN
        chk({t, " err"}, {7'b0, b8.err}, 8'h00);
`endif
    endtask

    // Monitor: one comparison set per queued entry, sampled 2 ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q8.size() > 0) begin
                e = q8.pop_front();
                cmp(e, b8.Y, b8.busy, b8.done);
`ifdef STROBE_DECODER_ERR_EN
                chk({e.tag, " err"}, {7'b0, b8.err}, {7'b0, e.err});
`endif
            end
            if (q6.size() > 0) begin
                e = q6.pop_front();
                cmp(e, {2'b00, b6.Y}, b6.busy, b6.done);
`ifdef STROBE_DECODER_ERR_EN
                chk({e.tag, " err"}, {7'b0, b6.err}, {7'b0, e.err});
`endif
            end
        end
    end

    initial begin
        b8.Enable1_bar = 1'b0; b8.Enable2_bar = 1'b0; b8.Enable3 = 1'b1; b8.req = 1'b0; b8.A = '0;
        b6.Enable1_bar = 1'b0; b6.Enable2_bar = 1'b0; b6.Enable3 = 1'b1; b6.req = 1'b0; b6.A = '0;
        err8 = 1'b0;
        mr_n = 1'b1;
        #1 mr_n = 1'b0;
        #1 rst_chk("reset");
        repeat (2) @(negedge clk);
        mr_n = 1'b1;

        // Request without enable is ignored.
        s8(1, 0, 3'd5, 8'hFF, 0, 0, 0, "noen");
        // Basic strobe on A=5; A/req changes while busy are ignored.
        s8(1, 1, 3'd5, 8'hFF, 1, 0, 0, "basic e0");
        s8(0, 1, 3'd1, 8'hDF, 1, 0, 0, "basic e1");
        s8(1, 1, 3'd1, 8'hDF, 1, 0, 0, "basic e2");
        s8(0, 1, 3'd1, 8'hFF, 1, 0, 0, "basic e3");
        s8(0, 1, 3'd1, 8'hFF, 0, 1, 0, "basic e4");
        s8(0, 1, 3'd1, 8'hFF, 0, 0, 0, "basic idle");

        // Back-to-back: A=0 then A=7 accepted in the done cycle.
        s8(1, 1, 3'd0, 8'hFF, 1, 0, 0, "b2b a0 e0");
        s8(0, 1, 3'd0, 8'hFE, 1, 0, 0, "b2b a0 e1");
        s8(0, 1, 3'd7, 8'hFE, 1, 0, 0, "b2b a0 e2");
        s8(0, 1, 3'd7, 8'hFF, 1, 0, 0, "b2b a0 e3");
        s8(0, 1, 3'd7, 8'hFF, 0, 1, 0, "b2b a0 done");
        s8(1, 1, 3'd7, 8'hFF, 1, 0, 0, "b2b a7 e0");
        s8(0, 1, 3'd2, 8'h7F, 1, 0, 0, "b2b a7 e1");
        s8(0, 1, 3'd2, 8'h7F, 1, 0, 0, "b2b a7 e2");
        s8(0, 1, 3'd2, 8'hFF, 1, 0, 0, "b2b a7 e3");
        s8(0, 1, 3'd2, 8'hFF, 0, 1, 0, "b2b a7 done");

        // Abort: Enable3 drops during ACTIVE.
        s8(1, 1, 3'd2, 8'hFF, 1, 0, 0, "abort e0");
        s8(0, 1, 3'd2, 8'hFB, 1, 0, 0, "abort e1");
        err8 = ERR_BUILD;
        s8(0, 0, 3'd2, 8'hFF, 0, 0, err8, "abort e2");
        s8(0, 1, 3'd2, 8'hFF, 0, 0, err8, "abort after1");
        s8(0, 1, 3'd2, 8'hFF, 0, 0, err8, "abort after2");

        // Asynchronous reset in the middle of an A=3 pulse.
        s8(1, 1, 3'd3, 8'hFF, 1, 0, err8, "rst e0");
        s8(0, 1, 3'd3, 8'hF7, 1, 0, err8, "rst e1");
        @(posedge clk);
        #4 mr_n = 1'b0;
        #1 rst_chk("midreset");
        err8 = 1'b0;
        @(negedge clk);
        mr_n = 1'b1;
        for (int i = 0; i < 5; i++) s8(0, 1, 3'd3, 8'hFF, 0, 0, 0, "post-reset idle");

        // Address with unknown bits; a two-state simulator sees some fixed value instead.
        xa = 3'bx1x;
        xunk = $isunknown(xa);
        if (xunk) begin
`ifdef STROBE_DECODER_ERR_EN
            s8(1, 1, xa, 8'hFF, 0, 0, 1, "xaddr accept");
            s8(0, 1, xa, 8'hFF, 0, 0, 1, "xaddr idle");
`else
            s8(1, 1, xa, 8'hFF, 1, 0, 0, "xaddr e0");
            s8(0, 1, xa, 8'hxx, 1, 0, 0, "xaddr e1");
            s8(0, 1, xa, 8'hxx, 1, 0, 0, "xaddr e2");
            s8(0, 1, xa, 8'hFF, 1, 0, 0, "xaddr e3");
            s8(0, 1, xa, 8'hFF, 0, 1, 0, "xaddr done");
`endif
        end else begin
            yx = 8'd1;
            yx = ~(yx << xa);
            s8(1, 1, xa, 8'hFF, 1, 0, 0, "xaddr e0");
            s8(0, 1, xa, yx,    1, 0, 0, "xaddr e1");
            s8(0, 1, xa, yx,    1, 0, 0, "xaddr e2");
            s8(0, 1, xa, 8'hFF, 1, 0, 0, "xaddr e3");
            s8(0, 1, xa, 8'hFF, 0, 1, 0, "xaddr done");
        end
        @(negedge clk);
        mr_n = 1'b0;
        #1 rst_chk("xreset");
        @(negedge clk);
        mr_n = 1'b1;
        s8(0, 1, 3'd0, 8'hFF, 0, 0, 0, "xreset idle");

        // Six outputs, no setup/hold, one-cycle pulse.
        s6(1, 3'd4, 6'b101111, 1, 0, 0, "w6 a4 e0");
        s6(0, 3'd4, 6'h3F, 0, 1, 0, "w6 a4 done");
        s6(0, 3'd4, 6'h3F, 0, 0, 0, "w6 a4 idle");
`ifdef STROBE_DECODER_ERR_EN
        s6(1, 3'd6, 6'h3F, 0, 0, 1, "w6 a6 reject");
        s6(0, 3'd6, 6'h3F, 0, 0, 1, "w6 a6 idle");
`else
        s6(1, 3'd6, 6'h3F, 1, 0, 0, "w6 a6 e0");
        s6(0, 3'd6, 6'h3F, 0, 1, 0, "w6 a6 done");
        s6(0, 3'd6, 6'h3F, 0, 0, 0, "w6 a6 idle");
`endif

        repeat (2) @(negedge clk);
        checks++;
        if (q8.size() != 0 || q6.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", q8.size(), q6.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
